// File: rtl/seq_int_divider.sv
// seq_int_divider: radix-2 restoring integer divider with valid/ready handshake, signed/unsigned operands.
// Ports: clk, rst (async active-high); in_valid/in_ready, dividend, divisor, is_signed accept an operation;
// out_valid/out_ready, quotient, remainder, div_by_zero deliver the result. Optional macro SEQ_DIV_EARLY_TERM_EN
// lets trivial divisions (divisor magnitude > dividend magnitude, or == 1) skip the iteration phase.
module seq_int_divider #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    input  logic             is_signed,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);
    localparam int CNT_W = $clog2(WIDTH) + 1;
    typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;
    state_t            r_state, w_next;
    logic [CNT_W-1:0]  r_cnt;
    logic [WIDTH-1:0]  r_rem, r_quo, r_dvs, r_quotient, r_remainder;
    logic              r_sign_q, r_sign_r, r_dbz;
    logic              w_accept, w_dvd_neg, w_dvs_neg, w_dvs_zero, w_skip;
    logic [WIDTH-1:0]  w_dvd_mag, w_dvs_mag;
    logic [WIDTH:0]    w_rem_sh, w_trial;
    assign in_ready    = r_state == IDLE;
    assign out_valid   = r_state == DONE;
    assign quotient    = r_quotient;
    assign remainder   = r_remainder;
    assign div_by_zero = r_dbz;
    assign w_accept    = in_valid && r_state == IDLE;
    assign w_dvd_neg   = is_signed & dividend[WIDTH-1];
    assign w_dvs_neg   = is_signed & divisor[WIDTH-1];
    assign w_dvd_mag   = w_dvd_neg ? -dividend : dividend;
    assign w_dvs_mag   = w_dvs_neg ? -divisor : divisor;
    assign w_dvs_zero  = divisor == '0;
    // The shifted remainder can need WIDTH+1 bits; the trial result always fits a signed WIDTH+1 value.
    assign w_rem_sh    = {r_rem, r_quo[WIDTH-1]};
    assign w_trial     = w_rem_sh - {1'b0, r_dvs};
`ifdef SEQ_DIV_EARLY_TERM_EN
    logic w_skip_small, w_skip_one;
    assign w_skip_small = w_dvs_mag > w_dvd_mag;
    assign w_skip_one   = w_dvs_mag == WIDTH'(1);
    assign w_skip       = w_skip_small | w_skip_one;
`else
    assign w_skip = 1'b0;
`endif
    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    w_next = !w_accept ? IDLE : w_dvs_zero ? DONE : w_skip ? FIX : CALC;
            CALC:    w_next = r_cnt == CNT_W'(1) ? FIX : CALC;
            FIX:     w_next = DONE;
            default: w_next = out_ready ? IDLE : DONE;
        endcase
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_next;
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt       <= '0;
            r_rem       <= '0;
            r_quo       <= '0;
            r_dvs       <= '0;
            r_sign_q    <= 1'b0;
            r_sign_r    <= 1'b0;
            r_quotient  <= '0;
            r_remainder <= '0;
            r_dbz       <= 1'b0;
        end else begin
            case (r_state)
                IDLE: if (w_accept) begin
                    r_cnt    <= CNT_W'(WIDTH);
                    r_dvs    <= w_dvs_mag;
                    r_sign_q <= w_dvd_neg ^ w_dvs_neg;
                    r_sign_r <= w_dvd_neg;
                    r_rem    <= '0;
                    r_quo    <= w_dvd_mag;
`ifdef SEQ_DIV_EARLY_TERM_EN
                    if (w_skip_small) begin
                        r_quo <= '0;
                        r_rem <= w_dvd_mag;
                    end else if (w_skip_one) begin
                        r_quo <= w_dvd_mag;
                        r_rem <= '0;
                    end
`endif
                    if (w_dvs_zero) begin
                        r_quotient  <= '1;
                        r_remainder <= dividend;
                        r_dbz       <= 1'b1;
                    end
                end
                CALC: begin
                    r_cnt <= r_cnt - 1'b1;
                    r_rem <= w_trial[WIDTH] ? w_rem_sh[WIDTH-1:0] : w_trial[WIDTH-1:0];
                    r_quo <= {r_quo[WIDTH-2:0], ~w_trial[WIDTH]};
                end
                FIX: begin
                    r_quotient  <= r_sign_q ? -r_quo : r_quo;
                    r_remainder <= r_sign_r ? -r_rem : r_rem;
                    r_dbz       <= 1'b0;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_seq_int_divider.sv
// tb_seq_int_divider: randomized and directed checks of seq_int_divider against an arithmetic reference.
module tb_seq_int_divider;
    localparam int W = 32;
`ifdef SEQ_DIV_EARLY_TERM_EN
    localparam bit EARLY = 1'b1;
`else
    localparam bit EARLY = 1'b0;
`endif
    logic         clk = 1'b0, rst = 1'b1, in_valid = 1'b0, in_ready, is_signed = 1'b0;
    logic         out_valid, out_ready = 1'b1, div_by_zero;
    logic [W-1:0] dividend = '0, divisor = '0, quotient, remainder;
    int           total = 0, passed = 0;

    seq_int_divider #(.WIDTH(W)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .dividend(dividend), .divisor(divisor), .is_signed(is_signed),
        .out_valid(out_valid), .out_ready(out_ready),
        .quotient(quotient), .remainder(remainder), .div_by_zero(div_by_zero)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    // Reference: plain integer division on 64-bit values; SV / and % already truncate toward zero.
    task automatic model(input logic [W-1:0] a, input logic [W-1:0] b, input logic s,
                         output logic [W-1:0] q, output logic [W-1:0] r, output logic z, output int lat);
        longint sa, sb, qq, rr, ma, mb;
        sa = s ? longint'($signed(a)) : longint'({32'd0, a});
        sb = s ? longint'($signed(b)) : longint'({32'd0, b});
        ma = sa < 0 ? -sa : sa;
        mb = sb < 0 ? -sb : sb;
        if (b == '0) begin
            q = '1; r = a; z = 1'b1; lat = 0;
        end else begin
            qq = sa / sb; rr = sa % sb;
            q = qq[W-1:0]; r = rr[W-1:0]; z = 1'b0;
            lat = (EARLY && (mb > ma || mb == 1)) ? 1 : W + 1;
        end
    endtask

    task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic s, input int hold);
        logic [W-1:0] eq, er, hq;
        logic ez;
        int el, lat;
        model(a, b, s, eq, er, ez, el);
        @(negedge clk);
        dividend = a; divisor = b; is_signed = s; in_valid = 1'b1; out_ready = (hold == 0);
        chk("accept_ready", in_ready, 1);
        @(posedge clk); #1;
        in_valid = 1'b0; dividend = $urandom; divisor = $urandom; is_signed = $urandom_range(0, 1);
        chk("busy_ready", in_ready, 0);
        lat = 0;
        while (out_valid !== 1'b1 && lat < 100) begin
            @(posedge clk); #1;
            lat++;
        end
        chk("latency", lat, el);
        chk("quotient", quotient, eq);
        chk("remainder", remainder, er);
        chk("div_by_zero", div_by_zero, ez);
        hq = quotient;
        for (int i = 0; i < hold; i++) begin
            @(posedge clk); #1;
            chk("hold_valid", out_valid, 1);
            chk("hold_ready", in_ready, 0);
            chk("hold_quotient", quotient, hq);
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        chk("post_valid", out_valid, 0);
        chk("post_ready", in_ready, 1);
    endtask

    initial begin
        int bad;
        logic [W-1:0] b;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_ready", in_ready, 1);
        chk("rst_valid", out_valid, 0);
        chk("rst_quotient", quotient, 0);
        chk("rst_remainder", remainder, 0);
        chk("rst_dbz", div_by_zero, 0);
        @(negedge clk) rst = 1'b0;

        do_op(32'd100, 32'd7, 1'b0, 0);
        do_op(32'hFFFFFF9C, 32'd7, 1'b1, 0);
        do_op(32'd100, 32'hFFFFFFF9, 1'b1, 0);
        do_op(32'h12345678, 32'd0, 1'b0, 0);
        do_op(32'h80000000, 32'hFFFFFFFF, 1'b1, 0);
        do_op(32'hFFFFFFFF, 32'd1, 1'b0, 0);
        do_op(32'd5, 32'd9, 1'b0, 0);
        do_op(32'hFFFFFFFF, 32'hFFFFFFFE, 1'b0, 0);
        do_op(32'd12345, 32'd100, 1'b0, 5);

        for (int i = 0; i < 24; i++) begin
            case ($urandom_range(0, 3))
                0:       b = $urandom;
                1:       b = $urandom_range(1, 300);
                2:       b = -$urandom_range(1, 300);
                default: b = (i % 6 == 0) ? '0 : ($urandom >> $urandom_range(0, 31));
            endcase
            do_op($urandom, b, $urandom_range(0, 1), 0);
        end

        @(negedge clk);
        dividend = 32'd200; divisor = 32'd3; is_signed = 1'b0; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (10) @(posedge clk);
        #2 rst = 1'b1;
        #1;
        chk("abort_valid", out_valid, 0);
        chk("abort_ready", in_ready, 1);
        chk("abort_quotient", quotient, 0);
        chk("abort_remainder", remainder, 0);
        @(negedge clk) rst = 1'b0;
        bad = 0;
        repeat (W + 5) begin
            @(posedge clk); #1;
            if (out_valid !== 1'b0) bad++;
        end
        chk("abort_no_result", bad, 0);
        do_op(32'd77, 32'd8, 1'b0, 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
